// File: rtl/icache_sa.sv
// Set-associative instruction cache with multi-word blocks, round-robin replacement
// and whole-cache invalidate. Hits are combinational; misses fill a block word by word.
module icache_sa #(
  parameter int SETS     = 8,
  parameter int WAYS     = 2,
  parameter int BLKWORDS = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iflush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX  = $clog2(SETS);
  localparam int OFF  = $clog2(BLKWORDS);
  localparam int OFFW = (OFF > 0) ? OFF : 1;
  localparam int TAG  = 30 - IDX - OFF;
  localparam int WAYW = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FILL} state_t;

  state_t             state;
  logic [OFFW-1:0]    k;
  logic               flushpend;
  logic [TAG-1:0]     misstag;
  logic [IDX-1:0]     missidx;
  logic [WAYW-1:0]    missway;

  logic [WAYS-1:0]    valid [SETS];
  logic [WAYW-1:0]    rr    [SETS];
  logic [TAG-1:0]     tags  [SETS][WAYS];
  logic [31:0]        data  [SETS][WAYS][BLKWORDS];

  logic [TAG-1:0]     reqtag;
  logic [IDX-1:0]     reqidx;
  logic [OFFW-1:0]    reqoff;
  logic [31:0]        filladdr;
  logic               hitany;
  logic [WAYW-1:0]    hitway;
  logic [WAYW-1:0]    victim;
  logic               freeway;
  logic               missstart;
  logic               lastword;
  logic               unused_addrbits;

  assign unused_addrbits = ^imemaddr[1:0];
  assign reqtag = imemaddr[31 -: TAG];
  assign reqidx = imemaddr[2+OFF +: IDX];

  // Single-word blocks have no offset field, so the word counter is a dummy bit.
  if (OFF > 0) begin : g_off
    assign reqoff   = imemaddr[2 +: OFFW];
    assign filladdr = {misstag, missidx, k, 2'b00};
  end else begin : g_nooff
    assign reqoff   = '0;
    assign filladdr = {misstag, missidx, 2'b00};
  end

  always_comb begin
    hitany = 1'b0;
    hitway = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[reqidx][w] && (tags[reqidx][w] == reqtag)) begin
        hitany = 1'b1;
        hitway = WAYW'(w);
      end
    end
  end

  // Scanning downward leaves the lowest-index invalid way as the victim.
  always_comb begin
    victim  = rr[reqidx];
    freeway = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[reqidx][w]) begin
        victim  = WAYW'(w);
        freeway = 1'b1;
      end
    end
  end

  assign ihit      = (state == IDLE) && imemREN && !iflush && hitany;
  assign imemload  = ihit ? data[reqidx][hitway][reqoff] : 32'h0;
  assign missstart = (state == IDLE) && imemREN && !iflush && !hitany;
  assign lastword  = (k == OFFW'(BLKWORDS - 1));
  assign iREN      = (state == FILL);
  assign iaddr     = (state == FILL) ? filladdr : 32'h0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      k         <= '0;
      flushpend <= 1'b0;
      misstag   <= '0;
      missidx   <= '0;
      missway   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        rr[s]    <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (iflush) begin
            for (int s = 0; s < SETS; s++) begin
              valid[s] <= '0;
              rr[s]    <= '0;
            end
          end else if (missstart) begin
            misstag                <= reqtag;
            missidx                <= reqidx;
            missway                <= victim;
            k                      <= '0;
            valid[reqidx][victim]  <= 1'b0;
            if (!freeway)
              rr[reqidx] <= (WAYS > 1) ? rr[reqidx] + 1'b1 : '0;
            state                  <= FILL;
          end
        end
        FILL: begin
          if (iflush)
            flushpend <= 1'b1;
          if (!iwait) begin
            k <= k + 1'b1;
            if (lastword) begin
              state <= IDLE;
              // A flush seen anytime during the fill wins over validating the new block.
              if (flushpend || iflush) begin
                flushpend <= 1'b0;
                for (int s = 0; s < SETS; s++) begin
                  valid[s] <= '0;
                  rr[s]    <= '0;
                end
              end else begin
                valid[missidx][missway] <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == FILL) && !iwait) begin
      data[missidx][missway][k] <= iload;
      if (lastword)
        tags[missidx][missway] <= misstag;
    end
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache with multi-word blocks, round-robin replacement and whole-cache invalidate. Sits between the datapath fetch port (datapath_cache_if icache modport) and the memory-side cache interface (caches_if), replacing the direct-mapped single-word icache. Hits return data combinationally in the request cycle. Misses fetch a full block word by word through the memory arbiter.

## Interface
- SETS, 8: number of sets; power of 2, ≥2
- WAYS, 2: associativity; 1, 2 or 4
- BLKWORDS, 2: 32-bit words per block; power of 2, ≥1
- Derived field widths: IDX=log2(SETS), OFF=log2(BLKWORDS), TAG=30−IDX−OFF
- Byte-address split: imemaddr[1:0] ignored; [2+:OFF] word offset; [2+OFF+:IDX] index; [31:32−TAG] tag

- CLK  in  1  system clock, rising edge
- nRST  in  1  asynchronous active-low reset
- dcif.imemREN  in  1  fetch request
- dcif.imemaddr  in  32  fetch byte address
- dcif.ihit  out  1  fetch data valid this cycle
- dcif.imemload  out  32  fetched instruction
- iflush  in  1  invalidate all blocks (single-cycle pulse or level)
- cif.iREN  out  1  memory read request
- cif.iaddr  out  32  memory word address, byte-aligned
- cif.iwait  in  1  memory busy; low = cif.iload valid this cycle
- cif.iload  in  32  memory read data
- One clock; reset is asynchronous and active-low (CLK, nRST).

## Operation
- Storage per set: WAYS × {valid, tag[TAG], data[BLKWORDS][32]}, plus a rr pointer of log2(WAYS) bits (absent when WAYS=1).
- Hit: state IDLE, imemREN=1, iflush=0, and some way in the indexed set is valid with a matching tag. Outputs ihit=1 and imemload = that way's data at the word offset. Multiple matches cannot occur.
- imemload is 0 when ihit=0.
- FSM states:
  - IDLE: on imemREN=1 with no hit and iflush=0, latch tag/index (missaddr), clear word counter k, select victim, go to FILL.
  - FILL: cif.iREN=1 and cif.iaddr = {missaddr tag, index, k, 2'b00}. Each cycle with iwait=0 writes iload into victim data[k] and increments k. When that write is for k=BLKWORDS−1: write the victim tag, set valid=1 (unless a flush is pending), return to IDLE.
- Victim selection: lowest-index invalid way; if all ways are valid, the way at rr[index], and rr[index] increments mod WAYS. rr changes only on this path.
- Valid is cleared at the start of a fill, so a partially filled block never hits.
- imemaddr changes during FILL are ignored; the fill always completes for missaddr.
- Flush:
  - iflush in IDLE clears all valid bits and rr pointers at the next edge; ihit=0 in that cycle and no miss starts.
  - iflush during FILL sets flush_pending. The fill runs to completion but the block is not validated. At the IDLE transition all valid bits and rr pointers clear and flush_pending clears.
- Data and tag arrays need no reset; valid bits, rr pointers, state, k and flush_pending do.

## Timing
- Reset values: state IDLE, all valid 0, rr 0, k 0, flush_pending 0. Outputs: ihit 0, imemload 0, cif.iREN 0, cif.iaddr 0.
- Reset is asynchronous mid-fill: cif.iREN drops immediately and the partial block is discarded (it stays invalid).
- Hit latency: 0 cycles (combinational, same cycle as imemREN).
- Miss cycle 0: no hit, FSM latches. cif.iREN asserts cycle 1.
- With iwait=0 always, ihit asserts in cycle BLKWORDS+1 (cycle 3 with defaults).
- Each wait cycle adds one. cif.iaddr and cif.iREN are held stable while iwait=1.
- cif.iaddr is 0 in IDLE.
- ihit is never 1 in FILL.

## Test plan
- Cold miss/fill, defaults, iwait=0, iload = 0xA000_0000|iaddr. Reset, then read 0x0000_0040. Required: iaddr 0x40 in cycle 1, 0x44 in cycle 2; ihit=1 in cycle 3 with imemload=0xA000_0040. Reading 0x44 next cycle hits with 0xA000_0044.
- Replacement. Fill 0x040, then 0x080 (both set 0): both hit. Then read 0x0C0: it evicts way0 (0x040). Required: 0x080 and 0x0C0 hit, 0x040 misses. Next miss to set 0 evicts way1.
- Wait states: iwait=1 for 3 cycles before each word. Required: iREN held 8 cycles, iaddr 0x40 for 4 cycles then 0x44 for 4 cycles, ihit in cycle 9.
- Flush in IDLE: fill 0x040 and 0x100, pulse iflush one cycle. Required: ihit=0 during the pulse; both addresses then miss and refill.
- Flush mid-fill: assert iflush in cycle 1 of a fill of 0x040. Required: word 0x44 is still fetched, no ihit in cycle 3, and an immediate re-miss on 0x040 with iREN=1 in cycle 4.
- Reset mid-fill: drop nRST during cycle 2 of a fill. Required: iREN=0 immediately. After release, 0x040 misses.
